// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, the
// decode-side handshake, the execute redirect and the sticky error flag.
interface ifu_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_err;

    // Fetch unit side
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output id_valid,
        input  id_ready,
        output id_inst,
        output id_pc,
        input  redirect_valid,
        input  redirect_pc,
        output fetch_err
    );

    // Environment side: memory, decode and execute
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  id_valid,
        output id_ready,
        input  id_inst,
        input  id_pc,
        output redirect_valid,
        output redirect_pc,
        input  fetch_err
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, keeps at most one instruction-memory
// read outstanding, and hands {inst, pc} to decode. Redirects from execute
// restart fetch; a misaligned redirect target halts fetch until reset.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);
    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP,
        ST_HALT
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic            id_valid_reg;
    logic [XLEN-1:0] id_inst_reg;
    logic [XLEN-1:0] id_pc_reg;
    logic            fetch_err_reg;

    logic            req_fire;
    logic            redirect_misaligned;

    // Request is a pure decode of the registered state; it is held low while
    // reset is asserted so nothing leaks out during the reset cycle itself.
    assign bus.imem_req_valid = (state_reg == ST_REQ) && !rst;
    assign bus.imem_req_addr  = {pc_reg[XLEN-1:2], 2'b00};
    assign bus.id_valid       = id_valid_reg;
    assign bus.id_inst        = id_inst_reg;
    assign bus.id_pc          = id_pc_reg;
    assign bus.fetch_err      = fetch_err_reg;

    assign req_fire            = (state_reg == ST_REQ) && bus.imem_req_ready;
    assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);

    // Fetch FSM with PC and decode-side output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_REQ;
            pc_reg        <= XLEN'(RESET_PC);
            id_valid_reg  <= 1'b0;
            id_inst_reg   <= '0;
            id_pc_reg     <= '0;
            fetch_err_reg <= 1'b0;
        end else if (bus.redirect_valid && (state_reg != ST_HALT)) begin
            // Redirect squashes any held instruction, even one decode is
            // accepting this very cycle; the PC does not advance past it.
            id_valid_reg <= 1'b0;
            if (redirect_misaligned) begin
                fetch_err_reg <= 1'b1;
                state_reg     <= ST_HALT;
            end else begin
                pc_reg <= bus.redirect_pc;
                unique case (state_reg)
                    // A request accepted in the same cycle still owes a response.
                    ST_REQ:  state_reg <= req_fire ? ST_DROP : ST_REQ;
                    ST_WAIT: state_reg <= bus.imem_rsp_valid ? ST_REQ : ST_DROP;
                    ST_HOLD: state_reg <= ST_REQ;
                    // The owed response may land in the redirect cycle; if it
                    // does, nothing is outstanding any more.
                    ST_DROP: state_reg <= bus.imem_rsp_valid ? ST_REQ : ST_DROP;
                    default: state_reg <= state_reg;
                endcase
            end
        end else begin
            unique case (state_reg)
                ST_REQ: begin
                    if (bus.imem_req_ready) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        id_inst_reg  <= bus.imem_rsp_data;
                        id_pc_reg    <= pc_reg;
                        id_valid_reg <= 1'b1;
                        state_reg    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.id_ready) begin
                        pc_reg       <= pc_reg + XLEN'(4);
                        id_valid_reg <= 1'b0;
                        state_reg    <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (bus.imem_rsp_valid) begin
                        state_reg <= ST_REQ;
                    end
                end
                default: begin
                    // Halted: everything frozen until reset.
                    state_reg <= ST_HALT;
                end
            endcase
        end
    end
endmodule
